// File: rtl/cu_pkg.sv
// Shared encodings for the control-unit sequencer: states, opcodes, fault codes
// and the opcode-to-state decode used at every dispatch point.
package cu_pkg;

  localparam int STATE_W = 5;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 5'd0,
    S_LOADY    = 5'd1,
    S_LOADX    = 5'd2,
    S_STORE    = 5'd3,
    S_BRANCH   = 5'd4,
    S_ALUREZ   = 5'd5,
    S_MOVY     = 5'd6,
    S_ACCY     = 5'd7,
    S_MOVX     = 5'd8,
    S_ACCX     = 5'd9,
    S_PUSH     = 5'd10,
    S_POPY     = 5'd11,
    S_POPX     = 5'd12,
    S_DONE     = 5'd13,
    S_NOTHING  = 5'd14,
    S_STALL    = 5'd15,
    S_IRQ_SAVE = 5'd16,
    S_IRQ_JMP  = 5'd17,
    S_FAULT    = 5'd18,
    S_RETI     = 5'd19
  } state_e;

  localparam logic [7:0] OP_HALT        = 8'h00;
  localparam logic [7:0] OP_LOAD        = 8'h01;
  localparam logic [7:0] OP_STORE       = 8'h02;
  localparam logic [7:0] OP_BRC_FIRST   = 8'h03;
  localparam logic [7:0] OP_BRC_LAST    = 8'h06;
  localparam logic [7:0] OP_JMP         = 8'h07;
  localparam logic [7:0] OP_MOV         = 8'h10;
  localparam logic [7:0] OP_PUSH        = 8'h1C;
  localparam logic [7:0] OP_EI          = 8'h20;
  localparam logic [7:0] OP_DI          = 8'h21;
  localparam logic [7:0] OP_RETI        = 8'h22;
  localparam logic [7:0] OP_ILLEGAL_MIN = 8'h23;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_TIMEOUT = 2'b01;
  localparam logic [1:0] FC_ILLEGAL = 2'b10;

  // Conditional branches 0x03..0x06 test flags[op-3]; op[1:0]+1 gives that index.
  function automatic state_e decode_op(input logic [7:0] op, input logic reg_s,
                                       input logic acc_s, input logic [3:0] flags);
    state_e nxt;
    nxt = S_NOTHING;
    if (op >= OP_ILLEGAL_MIN)                  nxt = S_FAULT;
    else if (op == OP_HALT)                    nxt = S_DONE;
    else if (op == OP_LOAD)                    nxt = reg_s ? S_LOADY : S_LOADX;
    else if (op == OP_STORE)                   nxt = S_STORE;
    else if (op inside {[OP_BRC_FIRST:OP_BRC_LAST]})
      nxt = flags[2'(op[1:0] + 2'd1)] ? S_BRANCH : S_NOTHING;
    else if (op == OP_JMP)                     nxt = S_BRANCH;
    else if (op inside {[8'h0A:8'h0F], [8'h14:8'h17], 8'h1A, 8'h1B})
      nxt = S_ALUREZ;
    else if (op == OP_MOV) begin
      case ({reg_s, acc_s})
        2'b10:   nxt = S_MOVY;
        2'b11:   nxt = S_ACCY;
        2'b00:   nxt = S_MOVX;
        default: nxt = S_ACCX;
      endcase
    end
    else if (op inside {[8'h11:8'h13]})        nxt = S_STALL;
    else if (op == OP_PUSH)                    nxt = S_PUSH;
    else if (op inside {[8'h1D:8'h1F]})        nxt = reg_s ? S_POPY : S_POPX;
    else if (op == OP_RETI)                    nxt = S_RETI;
    return nxt;
  endfunction

endpackage

// File: rtl/cu_stall_timer.sv
// Counts cycles spent in STALL; expired marks the last cycle the ALU may take.
module cu_stall_timer #(
  parameter int STALL_MAX = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_MAX - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == CNT_LAST);

endmodule

// File: rtl/cu_sequencer.sv
// Moore control-unit sequencer: opcode dispatch, ALU stall watchdog,
// illegal-opcode trap and vectored interrupt entry/return.
//
// state     | meaning
// IDLE      | waiting for start, datapath held in reset
// LOADY/X   | load operand register Y / X
// STORE     | store result
// BRANCH    | taken branch or jump
// ALUREZ    | write single-cycle ALU result
// MOVY/X    | move with accumulator on Y / X
// ACCY/X    | accumulate on Y / X
// PUSH      | push onto stack
// POPY/X    | pop into Y / X
// DONE      | halt acknowledged, returns to IDLE
// NOTHING   | no-op (untaken branch, EI, DI, reserved)
// STALL     | waiting on multi-cycle ALU, watchdog running
// IRQ_SAVE  | push return context
// IRQ_JMP   | branch to interrupt vector, acknowledge
// FAULT     | trapped, waits for start
// RETI      | pop return context, re-enable interrupts
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int OPCODE_W  = 6,
  parameter int STALL_MAX = 32,
  parameter int IRQ_EN    = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                ALU_ready,
  input  logic                reg_s,
  input  logic                acc_s,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [3:0]          flags,
  input  logic                irq,
  output logic                move,
  output logic                store,
  output logic                branch,
  output logic                pop,
  output logic                push,
  output logic                stall,
  output logic                str_rez,
  output logic                load_y,
  output logic                load_x,
  output logic                acc_opx,
  output logic                acc_opy,
  output logic                done,
  output logic                reset_cu,
  output logic                vec_sel,
  output logic                irq_ack,
  output logic                ie,
  output logic                fault,
  output logic [1:0]          fault_code,
  output logic [4:0]          state
);

  state_e     state_q, state_d;
  logic       ie_q, ie_d;
  logic [1:0] fault_code_q, fault_code_d;

  logic       dispatch, allow_irq;
  logic       timer_clr, timer_en, timer_expired;
  logic [7:0] op8;
  state_e     decoded;

  assign op8     = 8'(opcode);
  assign decoded = decode_op(op8, reg_s, acc_s, flags);

  cu_stall_timer #(.STALL_MAX(STALL_MAX)) u_stall_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d      = state_q;
    ie_d         = ie_q;
    fault_code_d = fault_code_q;
    dispatch     = 1'b0;
    allow_irq    = 1'b0;
    timer_en     = 1'b0;

    case (state_q)
      S_IDLE: dispatch = start;
      S_STALL: begin
        timer_en = 1'b1;
        if (ALU_ready) begin
          dispatch  = 1'b1;
          allow_irq = 1'b1;
        end else if (timer_expired) begin
          state_d      = S_FAULT;
          fault_code_d = FC_TIMEOUT;
        end
      end
      S_DONE:     state_d = S_IDLE;
      S_FAULT:    if (start) state_d = S_IDLE;
      S_IRQ_SAVE: state_d = S_IRQ_JMP;
      default: begin
        dispatch  = 1'b1;
        allow_irq = 1'b1;
      end
    endcase

    // Interrupt entry pre-empts decode, including HALT.
    if (dispatch) begin
      if (allow_irq && (IRQ_EN != 0) && ie_q && irq) begin
        state_d = S_IRQ_SAVE;
        ie_d    = 1'b0;
      end else begin
        state_d = decoded;
        if (op8 == OP_EI || op8 == OP_RETI) ie_d = 1'b1;
        else if (op8 == OP_DI)              ie_d = 1'b0;
        if (decoded == S_FAULT) fault_code_d = FC_ILLEGAL;
      end
    end

    timer_clr = dispatch && (state_d == S_STALL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      ie_q         <= 1'b0;
      fault_code_q <= FC_NONE;
    end else begin
      state_q      <= state_d;
      ie_q         <= ie_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign reset_cu   = (state_q == S_IDLE);
  assign move       = (state_q == S_MOVY) || (state_q == S_MOVX);
  assign store      = (state_q == S_STORE) || (state_q == S_PUSH) || (state_q == S_IRQ_SAVE);
  assign push       = (state_q == S_PUSH) || (state_q == S_IRQ_SAVE);
  assign branch     = (state_q == S_BRANCH) || (state_q == S_IRQ_JMP) || (state_q == S_RETI);
  assign vec_sel    = (state_q == S_IRQ_JMP);
  assign irq_ack    = (state_q == S_IRQ_JMP);
  assign pop        = (state_q == S_POPY) || (state_q == S_POPX) || (state_q == S_RETI);
  assign stall      = (state_q == S_STALL);
  assign str_rez    = (state_q == S_ALUREZ) || (state_q == S_MOVY) || (state_q == S_MOVX);
  assign load_y     = (state_q == S_LOADY) || (state_q == S_POPY);
  assign load_x     = (state_q == S_LOADX) || (state_q == S_POPX);
  assign acc_opy    = (state_q == S_MOVY) || (state_q == S_ACCY);
  assign acc_opx    = (state_q == S_MOVX) || (state_q == S_ACCX);
  assign done       = (state_q == S_DONE);
  assign fault      = (state_q == S_FAULT);
  assign ie         = ie_q;
  assign fault_code = fault_code_q;
  assign state      = state_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Bench for cu_sequencer: decode table, directed corner sequences and a
// randomized run against a cycle-level reference model of the sequencer rules.
module tb_cu_sequencer;

  localparam int STALL_MAX = 32;
  localparam int IDLE = 0, LOADY = 1, LOADX = 2, STORE = 3, BRANCH = 4, ALUREZ = 5,
                 MOVY = 6, ACCY = 7, MOVX = 8, ACCX = 9, PUSH = 10, POPY = 11,
                 POPX = 12, DONE = 13, NOTHING = 14, STALL = 15, IRQ_SAVE = 16,
                 IRQ_JMP = 17, FAULT = 18, RETI = 19;

  logic       clk = 1'b0, reset_n = 1'b0;
  logic       start = 1'b0, ALU_ready = 1'b0, reg_s = 1'b0, acc_s = 1'b0, irq = 1'b0;
  logic [5:0] opcode = '0;
  logic [3:0] flags = '0;

  logic move, store, branch, pop, push, stall, str_rez, load_y, load_x;
  logic acc_opx, acc_opy, done, reset_cu, vec_sel, irq_ack, ie, fault;
  logic [1:0] fault_code;
  logic [4:0] state;
  logic [15:0] dut_str;

  cu_sequencer #(.OPCODE_W(6), .STALL_MAX(STALL_MAX), .IRQ_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ALU_ready(ALU_ready),
    .reg_s(reg_s), .acc_s(acc_s), .opcode(opcode), .flags(flags), .irq(irq),
    .move(move), .store(store), .branch(branch), .pop(pop), .push(push),
    .stall(stall), .str_rez(str_rez), .load_y(load_y), .load_x(load_x),
    .acc_opx(acc_opx), .acc_opy(acc_opy), .done(done), .reset_cu(reset_cu),
    .vec_sel(vec_sel), .irq_ack(irq_ack), .ie(ie), .fault(fault),
    .fault_code(fault_code), .state(state)
  );

  assign dut_str = {move, store, branch, pop, push, stall, str_rez, load_y, load_x,
                    acc_opx, acc_opy, done, reset_cu, vec_sel, irq_ack, fault};

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int m_st = IDLE, m_stall = 0, m_fc = 0;
  bit m_ie = 1'b0;

  typedef struct {
    logic [5:0] op;
    bit         rs;
    bit         acc;
    logic [3:0] fl;
    int         exp_st;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int ref_decode(input int op, input bit rs, input bit acc,
                                    input logic [3:0] fl);
    if (op >= 'h23) return FAULT;
    if (op == 0) return DONE;
    if (op == 1) return rs ? LOADY : LOADX;
    if (op == 2) return STORE;
    if (op >= 3 && op <= 6) return fl[op-3] ? BRANCH : NOTHING;
    if (op == 7) return BRANCH;
    if (op inside {[10:15], [20:23], 26, 27}) return ALUREZ;
    if (op == 16) return rs ? (acc ? ACCY : MOVY) : (acc ? ACCX : MOVX);
    if (op >= 17 && op <= 19) return STALL;
    if (op == 28) return PUSH;
    if (op >= 29 && op <= 31) return rs ? POPY : POPX;
    if (op == 34) return RETI;
    return NOTHING;
  endfunction

  function automatic logic [15:0] ref_strobes(input int s);
    logic [15:0] v;
    v[15] = s inside {MOVY, MOVX};
    v[14] = s inside {STORE, PUSH, IRQ_SAVE};
    v[13] = s inside {BRANCH, IRQ_JMP, RETI};
    v[12] = s inside {POPY, POPX, RETI};
    v[11] = s inside {PUSH, IRQ_SAVE};
    v[10] = (s == STALL);
    v[9]  = s inside {ALUREZ, MOVY, MOVX};
    v[8]  = s inside {LOADY, POPY};
    v[7]  = s inside {LOADX, POPX};
    v[6]  = s inside {MOVX, ACCX};
    v[5]  = s inside {MOVY, ACCY};
    v[4]  = (s == DONE);
    v[3]  = (s == IDLE);
    v[2]  = (s == IRQ_JMP);
    v[1]  = (s == IRQ_JMP);
    v[0]  = (s == FAULT);
    return v;
  endfunction

  // m_stall = number of consecutive cycles spent in STALL, including the current one.
  task automatic model_edge();
    int nst;
    bit can_disp, irq_ok;
    nst = m_st; can_disp = 1'b0; irq_ok = 1'b1;
    if (m_st == IDLE) begin
      can_disp = start; irq_ok = 1'b0;
    end else if (m_st == STALL) begin
      if (ALU_ready) can_disp = 1'b1;
      else if (m_stall >= STALL_MAX) begin nst = FAULT; m_fc = 1; end
    end else if (m_st == DONE) nst = IDLE;
    else if (m_st == FAULT) begin if (start) nst = IDLE; end
    else if (m_st == IRQ_SAVE) nst = IRQ_JMP;
    else can_disp = 1'b1;
    if (can_disp) begin
      if (irq_ok && m_ie && irq) begin
        nst = IRQ_SAVE; m_ie = 1'b0;
      end else begin
        nst = ref_decode(int'(opcode), reg_s, acc_s, flags);
        if (opcode == 6'h20 || opcode == 6'h22) m_ie = 1'b1;
        if (opcode == 6'h21) m_ie = 1'b0;
        if (nst == FAULT) m_fc = 2;
      end
    end
    m_stall = (nst != STALL) ? 0 : (can_disp ? 1 : m_stall + 1);
    m_st = nst;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("state", int'(state), m_st);
    chk("strobes", int'(dut_str), int'(ref_strobes(m_st)));
    chk("ie", int'(ie), int'(m_ie));
    chk("fault_code", int'(fault_code), m_fc);
  endtask

  task automatic recover();
    start = 1'b0; opcode = '0; ALU_ready = 1'b1; irq = 1'b0;
    for (int k = 0; k < 8 && state != 5'(IDLE); k++) begin
      start = (state == 5'(FAULT));
      step();
    end
    chk("recover_idle", int'(state), IDLE);
    start = 1'b0; ALU_ready = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    #2 reset_n = 1'b0;
    #1;
    m_st = IDLE; m_ie = 1'b0; m_fc = 0; m_stall = 0;
    chk({tag, "_state"}, int'(state), IDLE);
    chk({tag, "_strobes"}, int'(dut_str), 16'h0008);
    chk({tag, "_ie"}, int'(ie), 0);
    chk({tag, "_fc"}, int'(fault_code), 0);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, actual running required finished");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    vecs.push_back('{6'h01, 1, 0, 4'h0, LOADY});
    vecs.push_back('{6'h01, 0, 0, 4'h0, LOADX});
    vecs.push_back('{6'h02, 0, 0, 4'h0, STORE});
    vecs.push_back('{6'h04, 0, 0, 4'b0010, BRANCH});
    vecs.push_back('{6'h04, 0, 0, 4'b0000, NOTHING});
    vecs.push_back('{6'h03, 0, 0, 4'b0001, BRANCH});
    vecs.push_back('{6'h05, 0, 0, 4'b1011, NOTHING});
    vecs.push_back('{6'h06, 0, 0, 4'b1000, BRANCH});
    vecs.push_back('{6'h06, 0, 0, 4'b0111, NOTHING});
    vecs.push_back('{6'h07, 0, 0, 4'h0, BRANCH});
    vecs.push_back('{6'h08, 0, 0, 4'h0, NOTHING});
    vecs.push_back('{6'h19, 0, 0, 4'h0, NOTHING});
    vecs.push_back('{6'h0A, 0, 0, 4'h0, ALUREZ});
    vecs.push_back('{6'h14, 0, 0, 4'h0, ALUREZ});
    vecs.push_back('{6'h1B, 0, 0, 4'h0, ALUREZ});
    vecs.push_back('{6'h10, 1, 0, 4'h0, MOVY});
    vecs.push_back('{6'h10, 1, 1, 4'h0, ACCY});
    vecs.push_back('{6'h10, 0, 0, 4'h0, MOVX});
    vecs.push_back('{6'h10, 0, 1, 4'h0, ACCX});
    vecs.push_back('{6'h11, 0, 0, 4'h0, STALL});
    vecs.push_back('{6'h13, 0, 0, 4'h0, STALL});
    vecs.push_back('{6'h1C, 0, 0, 4'h0, PUSH});
    vecs.push_back('{6'h1D, 1, 0, 4'h0, POPY});
    vecs.push_back('{6'h1F, 0, 0, 4'h0, POPX});
    vecs.push_back('{6'h20, 0, 0, 4'h0, NOTHING});
    vecs.push_back('{6'h21, 0, 0, 4'h0, NOTHING});
    vecs.push_back('{6'h22, 0, 0, 4'h0, RETI});
    vecs.push_back('{6'h23, 0, 0, 4'h0, FAULT});
    vecs.push_back('{6'h3F, 0, 0, 4'h0, FAULT});
    vecs.push_back('{6'h00, 0, 0, 4'h0, DONE});

    #12;
    chk("reset_state", int'(state), IDLE);
    chk("reset_strobes", int'(dut_str), 16'h0008);
    chk("reset_fc", int'(fault_code), 0);
    reset_n = 1'b1;

    // Load, halt, back to idle.
    start = 1'b1; opcode = 6'h01; reg_s = 1'b1; step();
    chk("tp_loady", int'(state), LOADY);
    chk("tp_load_y", int'(load_y), 1);
    start = 1'b0; opcode = 6'h00; step();
    chk("tp_done", int'(state), DONE);
    step();
    chk("tp_idle", int'(state), IDLE);

    foreach (vecs[i]) begin
      opcode = vecs[i].op; reg_s = vecs[i].rs; acc_s = vecs[i].acc; flags = vecs[i].fl;
      start = 1'b1; ALU_ready = 1'b0; irq = 1'b0;
      step();
      chk("vec_state", int'(state), vecs[i].exp_st);
      recover();
    end

    // ALU ready after five stall cycles.
    opcode = 6'h12; start = 1'b1; ALU_ready = 1'b0; step(); start = 1'b0;
    chk("stall_entry", int'(state), STALL);
    for (int k = 1; k < 5; k++) begin step(); chk("stall_hold", int'(state), STALL); end
    ALU_ready = 1'b1; opcode = 6'h02; step();
    chk("stall_exit", int'(state), STORE);
    recover();

    // Watchdog timeout.
    opcode = 6'h11; start = 1'b1; ALU_ready = 1'b0; step(); start = 1'b0;
    n = 0;
    while (state == 5'(STALL) && n < 100) begin n++; step(); end
    chk("stall_cycles", n, STALL_MAX);
    chk("timeout_state", int'(state), FAULT);
    chk("timeout_code", int'(fault_code), 1);
    start = 1'b1; step(); start = 1'b0;
    chk("fault_exit", int'(state), IDLE);
    chk("code_hold", int'(fault_code), 1);

    // Ready on the last allowed stall cycle still dispatches.
    opcode = 6'h13; start = 1'b1; ALU_ready = 1'b0; step(); start = 1'b0;
    for (int k = 1; k < STALL_MAX; k++) step();
    ALU_ready = 1'b1; opcode = 6'h07; step();
    chk("stall_last_ready", int'(state), BRANCH);
    recover();

    // Illegal opcode.
    opcode = 6'h2A; start = 1'b1; step();
    chk("illegal_state", int'(state), FAULT);
    chk("illegal_code", int'(fault_code), 2);
    recover();

    // EI with irq pending, interrupt entry, RETI.
    opcode = 6'h20; irq = 1'b1; start = 1'b1; step(); start = 1'b0;
    chk("ei_nothing", int'(state), NOTHING);
    chk("ei_ie", int'(ie), 1);
    step();
    chk("irq_save", int'(state), IRQ_SAVE);
    chk("irq_save_str", int'({push, store}), 3);
    chk("irq_save_ie", int'(ie), 0);
    step();
    chk("irq_jmp", int'(state), IRQ_JMP);
    chk("irq_jmp_str", int'({branch, vec_sel, irq_ack}), 7);
    irq = 1'b0; opcode = 6'h22; step();
    chk("reti", int'(state), RETI);
    chk("reti_str", int'({pop, branch}), 3);
    chk("reti_ie", int'(ie), 1);
    irq = 1'b1; opcode = 6'h00; step();
    chk("irq_over_halt", int'(state), IRQ_SAVE);
    recover();

    // DI masks a pending irq at the next dispatch.
    opcode = 6'h20; start = 1'b1; step(); start = 1'b0;
    opcode = 6'h21; step();
    chk("di_ie", int'(ie), 0);
    irq = 1'b1; opcode = 6'h02; step();
    chk("di_masked", int'(state), STORE);
    recover();

    // Asynchronous reset mid-STALL (ie set, fault code non-zero) and mid-IRQ_SAVE.
    opcode = 6'h20; start = 1'b1; step(); start = 1'b0;
    opcode = 6'h12; ALU_ready = 1'b0; step(); step();
    chk("pre_rst_stall", int'(state), STALL);
    async_reset("rst_stall");
    opcode = 6'h20; start = 1'b1; step(); start = 1'b0;
    irq = 1'b1; step();
    chk("pre_rst_irq", int'(state), IRQ_SAVE);
    async_reset("rst_irq");
    irq = 1'b0;

    for (int c = 0; c < 2500; c++) begin
      start     = ($urandom % 4) == 0;
      opcode    = (($urandom % 10) == 0) ? 6'($urandom_range(35, 63)) : 6'($urandom_range(0, 34));
      reg_s     = 1'($urandom);
      acc_s     = 1'($urandom);
      flags     = 4'($urandom);
      irq       = ($urandom % 8) == 0;
      ALU_ready = ($urandom % 6) == 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
